hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_CYCLES, default 32, giving the mult/div occupancy in cycles; legal range is 2..64.
REQ-002 The block SHALL have these ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- IDEXmemread  in  1  instruction in ID/EX is a load.
- IDEXrt  in  5  load destination register in ID/EX.
- IFIDrs  in  5  source register rs of the instruction in IF/ID.
- IFIDrt  in  5  source register rt of the instruction in IF/ID.
- NPCOp  in  2  next-PC select from ID; 00 = sequential, any other value = redirect (branch taken or jump).
- mdstart  in  1  mult/div issues in EX this cycle.
- mduse  in  1  instruction in ID reads HI/LO or is a mult/div.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register load enable.
- IFIDflush  out  1  zero the IF/ID register.
- IDEXflush  out  1  insert a bubble into ID/EX.
- mdbusy  out  1  mult/div unit is occupied.
- stallcnt  out  16  saturating count of stall cycles.

Function
REQ-003 The load-use hazard (lu) SHALL be IDEXmemread & (IDEXrt != 0) & (IDEXrt == IFIDrs | IDEXrt == IFIDrt), evaluated combinationally in the same cycle.
REQ-004 The mult/div hazard (mh) SHALL be mdbusy & mduse, evaluated combinationally.
REQ-005 stall SHALL be defined as lu | mh.
- PCWrite = ~stall.
- IFIDWrite = ~stall.
- IDEXflush = stall.
REQ-006 IFIDflush SHALL equal (NPCOp != 00) & ~stall; a stall suppresses the redirect flush in that cycle.
REQ-007 The FSM SHALL have two states, IDLE and MDBUSY, plus a 6-bit down-counter mdcnt.
REQ-008 In IDLE with mdstart=1, the block SHALL load mdcnt with MD_CYCLES-1 and enter MDBUSY on the next edge.
REQ-009 In MDBUSY with mdcnt != 0, the block SHALL decrement mdcnt each cycle.
REQ-010 In MDBUSY with mdcnt == 0, the block SHALL return to IDLE on the next edge.
REQ-011 mdbusy SHALL be 1 exactly while the state is MDBUSY, so it is high for MD_CYCLES cycles starting the cycle after mdstart.
REQ-012 mdstart in MDBUSY SHALL be ignored: no reload, no state change.
REQ-013 mdstart and mduse asserted in the same IDLE cycle SHALL NOT stall that cycle; the stall begins the next cycle.
REQ-014 stallcnt SHALL increment by 1 on each edge where stall=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-015 lu and mh asserted together SHALL produce a single stall, incrementing stallcnt by 1 per cycle.
REQ-016 The block SHALL NOT affect forwarding selects; forwarding remains the bypass unit's responsibility.

Reset
REQ-017 While rst=1 the block SHALL hold state=IDLE, mdcnt=0, mdbusy=0 and stallcnt=0, asynchronously.
REQ-018 While rst=1 the block SHALL force PCWrite=1, IFIDWrite=1, IFIDflush=0 and IDEXflush=0 regardless of inputs.
REQ-019 rst asserted during MDBUSY SHALL abort the operation immediately, with mdbusy dropping without waiting for a clock edge.
REQ-020 After rst deasserts, the first edge SHALL act on inputs normally.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load-use: IDEXmemread=1, IDEXrt=8, IFIDrs=8 -> PCWrite=0, IFIDWrite=0, IDEXflush=1 same cycle; stallcnt 0->1.
- Load to $0: IDEXmemread=1, IDEXrt=0, IFIDrt=0 -> no stall; PCWrite=1, stallcnt unchanged.
- Mult/div: MD_CYCLES=4, mdstart pulse at cycle 0, mduse=1 held -> mdbusy high cycles 1-4; stall cycles 1-4; PCWrite=1 at cycle 5; stallcnt=4.
- Redirect vs stall: NPCOp=01 with lu=1 -> IFIDflush=0, IDEXflush=1; next cycle lu=0, NPCOp=01 -> IFIDflush=1, PCWrite=1.
- Async reset mid-op: rst pulse between edges during MDBUSY with mdcnt=2 -> mdbusy=0 and stallcnt=0 before the next edge; IDLE afterwards.
- Saturation: force 65,537 consecutive stall cycles -> stallcnt holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and mult/div interlock for the pipeline front end.
// It generates the PC/IF-ID enables and the flushes, and counts stall cycles up to a saturating limit.
`default_nettype none

module hazard_ctrl #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEXmemread,
  input  logic [4:0]  IDEXrt,
  input  logic [4:0]  IFIDrs,
  input  logic [4:0]  IFIDrt,
  input  logic [1:0]  NPCOp,
  input  logic        mdstart,
  input  logic        mduse,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDflush,
  output logic        IDEXflush,
  output logic        mdbusy,
  output logic [15:0] stallcnt
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MDBUSY = 1'b1
  } state_t;

  localparam logic [5:0]  MD_LOAD = 6'(MD_CYCLES - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t     state;
  logic [5:0] mdcnt;
  logic       lu;
  logic       mh;
  logic       stall;

  // A load into $0 never produces a real value, so it cannot create a hazard.
  assign lu    = IDEXmemread && (IDEXrt != 5'd0) &&
                 ((IDEXrt == IFIDrs) || (IDEXrt == IFIDrt));
  assign mh    = mdbusy && mduse;
  assign stall = lu || mh;

  // Reset overrides the hazard outputs so the pipeline free-runs while held.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDflush = 1'b0;
    IDEXflush = 1'b0;
    if (!rst) begin
      PCWrite   = ~stall;
      IFIDWrite = ~stall;
      IDEXflush = stall;
      IFIDflush = (NPCOp != 2'b00) && !stall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mdcnt  <= 6'd0;
      mdbusy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mdstart) begin
            state  <= MDBUSY;
            mdcnt  <= MD_LOAD;
            mdbusy <= 1'b1;
          end
        end
        MDBUSY: begin
          // A new mdstart while occupied is ignored; the running count is not reloaded.
          if (mdcnt != 6'd0) begin
            mdcnt <= mdcnt - 6'd1;
          end else begin
            state  <= IDLE;
            mdbusy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          mdcnt  <= 6'd0;
          mdbusy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallcnt <= 16'd0;
    end else if (stall && (stallcnt != CNT_MAX)) begin
      stallcnt <= stallcnt + 16'd1;
    end
  end

endmodule

`default_nettype wire
